// File: rtl/mitm_select_scheduler.sv
// mitm_select_scheduler: switches mux select lines to the injected source only inside quiet bus windows.
module mitm_select_scheduler #(
    parameter int WIDTH        = 4,
    parameter int QUIET_CYCLES = 8,
    parameter int MAX_WAIT     = 1024,
    parameter int HOLD_W       = 16
) (
    input  logic              sys_clk,
    input  logic              n_reset,
    input  logic [WIDTH-1:0]  bus_in,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WIDTH-1:0]  req_mask,
    input  logic [HOLD_W-1:0] req_hold,
    input  logic              release_in,
    input  logic              abort,
    output logic [WIDTH-1:0]  select_line,
    output logic              busy,
    output logic              done,
    output logic              timeout
);
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, ARM, ACTIVE, DISARM} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  bus_prev_q;
    logic [QW-1:0]     quiet_q, quiet_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0] hold_lat_q, hold_lat_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [WIDTH-1:0]  select_line_q, select_line_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              change, quiet_ok;

    assign change      = |(bus_in ^ bus_prev_q);
    assign quiet_ok    = (quiet_q == QW'(QUIET_CYCLES)) && !change;
    assign req_ready   = (state_q == IDLE) && !abort;
    assign busy        = (state_q != IDLE);
    assign select_line = select_line_q;
    assign done        = done_q;
    assign timeout     = timeout_q;

    always_comb begin
        state_d       = state_q;
        mask_d        = mask_q;
        hold_lat_d    = hold_lat_q;
        hold_cnt_d    = hold_cnt_q;
        select_line_d = select_line_q;
        done_d        = 1'b0;
        timeout_d     = 1'b0;
        wait_d        = wait_q;
        quiet_d       = change ? '0 : (quiet_q == QW'(QUIET_CYCLES)) ? quiet_q : quiet_q + QW'(1);
        if (abort && state_q != IDLE) begin
            state_d       = IDLE;
            select_line_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        mask_d     = req_mask;
                        hold_lat_d = req_hold;
                        if (req_mask == '0) done_d = 1'b1;
                        else state_d = ARM;
                    end
                end
                ARM: begin
                    wait_d = wait_q + WW'(1);
                    // a quiet window arriving on the last wait cycle still wins over timeout
                    if (quiet_ok) begin
                        select_line_d = mask_q;
                        hold_cnt_d    = hold_lat_q;
                        state_d       = ACTIVE;
                    end else if (wait_q == WW'(MAX_WAIT - 1)) begin
                        state_d   = IDLE;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    if (release_in || hold_cnt_q == HOLD_W'(1)) state_d = DISARM;
                end
                DISARM: begin
                    if (quiet_ok) begin
                        select_line_d = '0;
                        state_d       = IDLE;
                        done_d        = 1'b1;
                    end
                end
            endcase
        end
        if (state_d != state_q) begin
            quiet_d = '0;
            wait_d  = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= IDLE;
            bus_prev_q    <= '0;
            quiet_q       <= '0;
            wait_q        <= '0;
            hold_cnt_q    <= '0;
            hold_lat_q    <= '0;
            mask_q        <= '0;
            select_line_q <= '0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_prev_q    <= bus_in;
            quiet_q       <= quiet_d;
            wait_q        <= wait_d;
            hold_cnt_q    <= hold_cnt_d;
            hold_lat_q    <= hold_lat_d;
            mask_q        <= mask_d;
            select_line_q <= select_line_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
        end
    end
endmodule
